// File: rtl/sad_best_match_pkg.sv
// rtl/sad_best_match_pkg.sv - shared widths, SAD pipe latency and FSM encoding
// Purpose: constants shared by the SAD best-match reducer, its interface and
//          the testbench; two-state search FSM encoding.
// Ports:   none (package).
package sad_best_match_pkg;

  localparam int SAD_W_DEF   = 14;  // 8x8 block of 8-bit pixels
  localparam int MV_W_DEF    = 16;  // {dx[7:0], dy[7:0]}, opaque here
  localparam int CNT_W_DEF   = 8;
  localparam int SAD_LATENCY = 6;   // SAD tree depth, pixels in -> sad out

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

endpackage

// File: rtl/sad_best_match_if.sv
// rtl/sad_best_match_if.sv - candidate/SAD input and result handshake bundle
// Purpose: groups the candidate tag inputs, the SAD pipe output and the
//          valid/ready result port of sad_best_match.
// Ports (slave = reducer view):
//   in : cand_valid, cand_first, cand_last, cand_mv, sad, res_ready
//   out: res_valid, res_sad, res_mv, res_count, res_overrun
interface sad_best_match_if
  import sad_best_match_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int MV_W  = MV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             cand_valid;
  logic             cand_first;
  logic             cand_last;
  logic [MV_W-1:0]  cand_mv;
  logic [SAD_W-1:0] sad;
  logic             res_valid;
  logic             res_ready;
  logic [SAD_W-1:0] res_sad;
  logic [MV_W-1:0]  res_mv;
  logic [CNT_W-1:0] res_count;
  logic             res_overrun;

  modport slave (
    input  cand_valid, cand_first, cand_last, cand_mv, sad, res_ready,
    output res_valid, res_sad, res_mv, res_count, res_overrun
  );

  modport master (
    output cand_valid, cand_first, cand_last, cand_mv, sad, res_ready,
    input  res_valid, res_sad, res_mv, res_count, res_overrun
  );

endinterface

// File: rtl/sad_tag_delay.sv
// rtl/sad_tag_delay.sv - fixed-depth tag shift register with asynchronous clear
// Purpose: delays a W-bit tag by DEPTH clocks so it lines up with the SAD
//          pipe output; never stalls.
// Ports:
//   clk  in  1      clock
//   aclr in  1      asynchronous active-high clear of every stage
//   din  in  W      tag entering the pipe this cycle
//   dout out W      tag entered DEPTH clocks earlier
module sad_tag_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sad_best_match.sv
// rtl/sad_best_match.sv - minimum-SAD tracker over a search window with result handshake
// Purpose: aligns candidate tags with the SAD pipe output, keeps the smallest
//          SAD (earliest wins ties) and its motion vector per window, and
//          presents the winner on a one-entry valid/ready result register.
// Ports:
//   clk  in  1   clock
//   aclr in  1   asynchronous active-high reset
//   bus  slave modport of sad_best_match_if (candidate tags, sad, result port)
module sad_best_match
  import sad_best_match_pkg::*;
#(
  parameter int SAD_W   = SAD_W_DEF,
  parameter int LATENCY = SAD_LATENCY,
  parameter int MV_W    = MV_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic             clk,
  input logic             aclr,
  sad_best_match_if.slave bus
);

  localparam int TAG_W = 3 + MV_W;

  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
  logic             d_valid;
  logic             d_first;
  logic             d_last;
  logic [MV_W-1:0]  d_mv;

  // first/last are masked here so an invalid cycle can never open or close a window.
  assign tag_in = {bus.cand_valid,
                   bus.cand_valid & bus.cand_first,
                   bus.cand_valid & bus.cand_last,
                   bus.cand_mv};

  sad_tag_delay #(.W(TAG_W), .DEPTH(LATENCY)) u_tag_delay (
    .clk  (clk),
    .aclr (aclr),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign {d_valid, d_first, d_last, d_mv} = tag_out;

  state_t           state;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_mv;
  logic [CNT_W-1:0] count;
  logic [SAD_W-1:0] nxt_sad;
  logic [MV_W-1:0]  nxt_mv;
  logic [CNT_W-1:0] nxt_count;
  logic             take;
  logic             close;
  logic             accept;

  // Running best including the current sample; also the value loaded into
  // the result register when the sample closes the window.
  always_comb begin
    nxt_sad   = best_sad;
    nxt_mv    = best_mv;
    nxt_count = count;
    if (d_first) begin
      nxt_sad   = bus.sad;
      nxt_mv    = d_mv;
      nxt_count = CNT_W'(1);
    end else begin
      if (count != {CNT_W{1'b1}}) nxt_count = count + 1'b1;
      if (bus.sad < best_sad) begin
        nxt_sad = bus.sad;
        nxt_mv  = d_mv;
      end
    end
  end

  // A non-first sample with no open window is dropped entirely.
  assign take   = d_valid & (d_first | (state == ST_SEARCH));
  assign close  = take & d_last;
  assign accept = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state           <= ST_IDLE;
      best_sad        <= '0;
      best_mv         <= '0;
      count           <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_sad     <= '0;
      bus.res_mv      <= '0;
      bus.res_count   <= '0;
      bus.res_overrun <= 1'b0;
    end else begin
      if (take) begin
        best_sad <= nxt_sad;
        best_mv  <= nxt_mv;
        count    <= nxt_count;
        state    <= d_last ? ST_IDLE : ST_SEARCH;
      end
      // A new result wins over a same-cycle handshake; overrun only flags a
      // result that was still pending and not being taken this cycle.
      if (close) begin
        bus.res_valid   <= 1'b1;
        bus.res_sad     <= nxt_sad;
        bus.res_mv      <= nxt_mv;
        bus.res_count   <= nxt_count;
        bus.res_overrun <= bus.res_valid & ~bus.res_ready;
      end else if (accept) begin
        bus.res_valid   <= 1'b0;
        bus.res_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_best_match.sv
// tb/tb_sad_best_match.sv - randomized self-checking bench for sad_best_match
module tb_sad_best_match;
  import sad_best_match_pkg::*;

  localparam int L = SAD_LATENCY;

  typedef struct packed {
    logic [13:0] sad;
    logic [15:0] mv;
    logic [7:0]  cnt;
    logic        ovr;
  } rec_t;

  logic clk  = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  sad_best_match_if #(.CNT_W(8)) bus8 ();
  sad_best_match_if #(.CNT_W(4)) bus4 ();

  sad_best_match #(.CNT_W(8)) dut  (.clk(clk), .aclr(aclr), .bus(bus8.slave));
  sad_best_match #(.CNT_W(4)) dut4 (.clk(clk), .aclr(aclr), .bus(bus4.slave));

  assign bus4.cand_valid = bus8.cand_valid;
  assign bus4.cand_first = bus8.cand_first;
  assign bus4.cand_last  = bus8.cand_last;
  assign bus4.cand_mv    = bus8.cand_mv;
  assign bus4.sad        = bus8.sad;
  assign bus4.res_ready  = bus8.res_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  rec_t        obs8[$];
  rec_t        obs4[$];
  int          obs_cyc[$];
  logic [13:0] sq[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (!aclr && bus8.res_valid) begin
      obs8.push_back({bus8.res_sad, bus8.res_mv, bus8.res_count, bus8.res_overrun});
      obs_cyc.push_back(cyc_cnt);
    end
    if (!aclr && bus4.res_valid)
      obs4.push_back({bus4.res_sad, bus4.res_mv, 4'b0, bus4.res_count, bus4.res_overrun});
  end

  // One clock of stimulus; the sad presented is the one queued L cycles ago,
  // which is how the real SAD pipe would deliver it.
  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [15:0] mv, input logic [13:0] s);
    @(posedge clk);
    #1;
    bus8.cand_valid = v;
    bus8.cand_first = f;
    bus8.cand_last  = l;
    bus8.cand_mv    = mv;
    bus8.sad        = sq[0];
    void'(sq.pop_front());
    sq.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 14'($urandom));
  endtask

  task automatic clear_obs();
    obs8.delete();
    obs4.delete();
    obs_cyc.delete();
  endtask

  task automatic reset_sad_pipe();
    sq.delete();
    for (int i = 0; i < L; i++) sq.push_back(14'd0);
  endtask

  function automatic rec_t model(input logic [13:0] s[$], input logic [15:0] m[$],
                                 input int sat);
    rec_t r;
    r.sad = s[0];
    r.mv  = m[0];
    for (int i = 1; i < s.size(); i++)
      if (s[i] < r.sad) begin
        r.sad = s[i];
        r.mv  = m[i];
      end
    r.cnt = 8'((s.size() > sat) ? sat : s.size());
    r.ovr = 1'b0;
    return r;
  endfunction

  task automatic test_reset();
    #2 aclr = 1'b1;
    #1;
    n_cmp++;
    if (bus8.res_valid !== 1'b0 || bus4.res_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b/%b expected 0", bus8.res_valid, bus4.res_valid);
    end
    n_cmp++;
    if ({bus8.res_sad, bus8.res_mv, bus8.res_count, bus8.res_overrun} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_result: got sad=%0d mv=%h cnt=%0d ovr=%b expected all 0",
               bus8.res_sad, bus8.res_mv, bus8.res_count, bus8.res_overrun);
    end
    repeat (2) @(posedge clk);
    #1 aclr = 1'b0;
  endtask

  task automatic test_basic();
    int lc;
    clear_obs();
    drive(1, 1, 0, 16'd0, 14'd300);
    drive(1, 0, 0, 16'd1, 14'd120);
    drive(1, 0, 0, 16'd2, 14'd450);
    drive(1, 0, 1, 16'd3, 14'd120);
    lc = cyc_cnt;
    idle(L + 4);
    n_cmp++;
    if (obs8.size() !== 1) begin
      n_bad++; $display("FAIL basic_pulses: got %0d valid cycles expected 1", obs8.size());
    end
    if (obs8.size() > 0) begin
      n_cmp++;
      if (obs8[0] !== rec_t'({14'd120, 16'd1, 8'd4, 1'b0})) begin
        n_bad++;
        $display("FAIL basic_result: got sad=%0d mv=%0d cnt=%0d ovr=%b expected 120/1/4/0",
                 obs8[0].sad, obs8[0].mv, obs8[0].cnt, obs8[0].ovr);
      end
      n_cmp++;
      if (obs_cyc[0] !== lc + L + 1) begin
        n_bad++; $display("FAIL basic_latency: got %0d clocks expected %0d", obs_cyc[0] - lc, L + 1);
      end
    end
  endtask

  task automatic test_one_cand();
    clear_obs();
    drive(1, 1, 1, 16'h1234, 14'd16383);
    idle(L + 3);
    n_cmp++;
    if (obs8.size() !== 1) begin
      n_bad++; $display("FAIL one_pulses: got %0d expected 1", obs8.size());
    end
    if (obs8.size() > 0) begin
      n_cmp++;
      if (obs8[0] !== rec_t'({14'd16383, 16'h1234, 8'd1, 1'b0})) begin
        n_bad++;
        $display("FAIL one_result: got sad=%0d mv=%h cnt=%0d ovr=%b expected 16383/1234/1/0",
                 obs8[0].sad, obs8[0].mv, obs8[0].cnt, obs8[0].ovr);
      end
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    bus8.res_ready = 1'b0;
    drive(1, 1, 0, 16'hA0, 14'd100);
    drive(1, 0, 1, 16'hA1, 14'd40);
    drive(1, 1, 0, 16'hB0, 14'd70);
    drive(1, 0, 0, 16'hB1, 14'd20);
    drive(1, 0, 1, 16'hB2, 14'd90);
    idle(L + 3);
    n_cmp++;
    if (obs8.size() < 2) begin
      n_bad++; $display("FAIL ovr_pulses: got %0d valid cycles expected at least 2", obs8.size());
    end else begin
      n_cmp++;
      if (obs8[0] !== rec_t'({14'd40, 16'hA1, 8'd2, 1'b0})) begin
        n_bad++;
        $display("FAIL ovr_first: got sad=%0d mv=%h cnt=%0d ovr=%b expected 40/a1/2/0",
                 obs8[0].sad, obs8[0].mv, obs8[0].cnt, obs8[0].ovr);
      end
      n_cmp++;
      if (obs8[obs8.size()-1] !== rec_t'({14'd20, 16'hB1, 8'd3, 1'b1})) begin
        n_bad++;
        $display("FAIL ovr_second: got sad=%0d mv=%h cnt=%0d ovr=%b expected 20/b1/3/1",
                 obs8[obs8.size()-1].sad, obs8[obs8.size()-1].mv,
                 obs8[obs8.size()-1].cnt, obs8[obs8.size()-1].ovr);
      end
    end
    bus8.res_ready = 1'b1;
    idle(2);
    n_cmp++;
    if (bus8.res_valid !== 1'b0 || bus8.res_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_accept: got valid=%b ovr=%b expected 0/0", bus8.res_valid, bus8.res_overrun);
    end
    // Back-to-back closes with ready high: second close lands on the handshake.
    clear_obs();
    drive(1, 1, 1, 16'hC0, 14'd500);
    drive(1, 1, 1, 16'hC1, 14'd501);
    idle(L + 3);
    n_cmp++;
    if (obs8.size() !== 2) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d expected 2", obs8.size());
    end else begin
      n_cmp++;
      if (obs8[0] !== rec_t'({14'd500, 16'hC0, 8'd1, 1'b0}) ||
          obs8[1] !== rec_t'({14'd501, 16'hC1, 8'd1, 1'b0}) ||
          obs_cyc[1] !== obs_cyc[0] + 1) begin
        n_bad++;
        $display("FAIL b2b_results: got %0d/%b,%0d/%b gap %0d expected 500/0,501/0 gap 1",
                 obs8[0].sad, obs8[0].ovr, obs8[1].sad, obs8[1].ovr, obs_cyc[1] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_restart();
    clear_obs();
    drive(1, 1, 0, 16'd1, 14'd50);
    drive(1, 0, 0, 16'd2, 14'd10);
    drive(1, 1, 0, 16'd7, 14'd80);
    drive(1, 0, 0, 16'd8, 14'd90);
    drive(1, 0, 1, 16'd9, 14'd95);
    idle(L + 3);
    n_cmp++;
    if (obs8.size() !== 1) begin
      n_bad++; $display("FAIL restart_pulses: got %0d expected 1", obs8.size());
    end else begin
      n_cmp++;
      if (obs8[0] !== rec_t'({14'd80, 16'd7, 8'd3, 1'b0})) begin
        n_bad++;
        $display("FAIL restart_result: got sad=%0d mv=%0d cnt=%0d expected 80/7/3",
                 obs8[0].sad, obs8[0].mv, obs8[0].cnt);
      end
    end
  endtask

  task automatic test_aclr_mid();
    bus8.res_ready = 1'b0;
    drive(1, 1, 1, 16'd5, 14'd33);
    idle(L + 1);
    drive(1, 1, 0, 16'd1, 14'd200);
    idle(L);
    drive(1, 0, 0, 16'd2, 14'd100);
    drive(1, 0, 1, 16'd3, 14'd50);
    @(posedge clk);
    #3 aclr = 1'b1;
    #1;
    n_cmp++;
    if ({bus8.res_valid, bus8.res_sad, bus8.res_mv, bus8.res_count, bus8.res_overrun} !== 40'd0 ||
        bus4.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL aclr_outputs: got valid=%b sad=%0d mv=%h cnt=%0d ovr=%b expected all 0",
               bus8.res_valid, bus8.res_sad, bus8.res_mv, bus8.res_count, bus8.res_overrun);
    end
    reset_sad_pipe();
    bus8.cand_valid = 1'b0;
    bus8.res_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 aclr = 1'b0;
    clear_obs();
    idle(L + 2);
    n_cmp++;
    if (obs8.size() !== 0 || obs4.size() !== 0) begin
      n_bad++; $display("FAIL aclr_quiet: got %0d/%0d valid cycles expected 0", obs8.size(), obs4.size());
    end
  endtask

  task automatic test_saturate();
    logic [13:0] s;
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      s = 14'($urandom_range(200, 1000));
      if (i == 17 || i == 19) s = 14'd3;
      drive(1, i == 0, i == 19, 16'(i), s);
    end
    idle(L + 3);
    n_cmp++;
    if (obs8.size() !== 1 || obs4.size() !== 1) begin
      n_bad++; $display("FAIL sat_pulses: got %0d/%0d expected 1/1", obs8.size(), obs4.size());
    end else begin
      n_cmp++;
      if (obs4[0] !== rec_t'({14'd3, 16'd17, 8'd15, 1'b0})) begin
        n_bad++;
        $display("FAIL sat_cnt4: got sad=%0d mv=%0d cnt=%0d expected 3/17/15",
                 obs4[0].sad, obs4[0].mv, obs4[0].cnt);
      end
      n_cmp++;
      if (obs8[0] !== rec_t'({14'd3, 16'd17, 8'd20, 1'b0})) begin
        n_bad++;
        $display("FAIL sat_cnt8: got sad=%0d mv=%0d cnt=%0d expected 3/17/20",
                 obs8[0].sad, obs8[0].mv, obs8[0].cnt);
      end
    end
  endtask

  task automatic test_random();
    rec_t        exp8[$];
    rec_t        exp4[$];
    logic [13:0] s[$];
    logic [15:0] m[$];
    int          n;
    clear_obs();
    for (int w = 0; w < 30; w++) begin
      s.delete();
      m.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        s.push_back(($urandom % 2) ? 14'($urandom_range(0, 15)) : 14'($urandom));
        m.push_back(16'($urandom));
        drive(1, i == 0, i == n - 1, m[i], s[i]);
      end
      exp8.push_back(model(s, m, 255));
      exp4.push_back(model(s, m, 15));
      idle($urandom_range(0, 3));
      if ($urandom % 4 == 0)
        drive(1, 0, 1'($urandom), 16'($urandom), 14'($urandom));
    end
    idle(L + 3);
    n_cmp++;
    if (obs8.size() !== exp8.size() || obs4.size() !== exp4.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d/%0d results expected %0d",
               obs8.size(), obs4.size(), exp8.size());
    end else begin
      for (int i = 0; i < exp8.size(); i++) begin
        n_cmp++;
        if (obs8[i] !== exp8[i] || obs4[i] !== exp4[i]) begin
          n_bad++;
          $display("FAIL rand_win%0d: got %h/%h expected %h/%h", i, obs8[i], obs4[i], exp8[i], exp4[i]);
        end
      end
    end
  endtask

  initial begin
    bus8.cand_valid = 1'b0;
    bus8.cand_first = 1'b0;
    bus8.cand_last  = 1'b0;
    bus8.cand_mv    = '0;
    bus8.sad        = '0;
    bus8.res_ready  = 1'b1;
    reset_sad_pipe();
    test_reset();
    test_basic();
    test_one_cand();
    test_overrun();
    test_restart();
    test_aclr_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
